// File: rtl/viterbi_tb_ctrl.sv
// Traceback scheduler for the K=5 rate-1/2 Viterbi core: stores ACS decision
// vectors in a circular survivor memory, traces back one step per cycle and streams decoded bits.
module viterbi_tb_ctrl #(
   parameter  int K    = 5,
   parameter  int D_TB = 32,
   localparam int S    = 2 ** (K - 1),
   localparam int SW   = K - 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          acs_valid,
   output logic          acs_ready,
   input  logic [S-1:0]  acs_dec,
   input  logic [SW-1:0] acs_best,
   input  logic          flush,
   output logic          out_valid,
   input  logic          out_ready,
   output logic          out_bit,
   output logic          out_last,
   output logic          flush_done,
   output logic          busy
);

   localparam int PW = $clog2(D_TB);
   localparam int PD = PW + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      TB   = 2'd1,
      EMIT = 2'd2
   } state_t;

   state_t        state_r, state_s;
   logic [S-1:0]  mem_r [D_TB];
   logic          mem_we_s;
   logic [PW-1:0] wr_ptr_r, wr_ptr_s;
   logic [PD-1:0] pend_r, pend_s;
   logic [SW-1:0] best_r, best_s;
   logic [SW-1:0] tb_state_r, tb_state_s;
   logic [PW-1:0] tb_ptr_r, tb_ptr_s;
   logic [PW-1:0] steps_r, steps_s;
   logic          flushing_r, flushing_s;
   logic          out_bit_r, out_bit_s;
   logic          out_last_r, out_last_s;
   logic          out_valid_r;
   logic          flush_done_r, flush_done_s;
   logic          busy_r;
   logic          dec_s;
   logic [SW-1:0] tb_step_s;
   logic [PW-1:0] newest_s;

   assign acs_ready  = (state_r == IDLE) & ~flush;
   assign out_valid  = out_valid_r;
   assign out_bit    = out_bit_r;
   assign out_last   = out_last_r;
   assign flush_done = flush_done_r;
   assign busy       = busy_r;

   // One traceback step: the stored decision becomes the predecessor MSB.
   assign dec_s     = mem_r[tb_ptr_r][tb_state_r];
   assign tb_step_s = {dec_s, tb_state_r[SW-1:1]};
   assign newest_s  = wr_ptr_r - PW'(1);

   // Survivor memory write port; contents are don't-care while nothing is pending.
   always_ff @(posedge clk) begin
      if (mem_we_s) begin
         mem_r[wr_ptr_r] <= acs_dec;
      end
   end

   // Next-state and next-output logic for the IDLE/TB/EMIT sequencer.
   always_comb begin
      state_s      = state_r;
      mem_we_s     = 1'b0;
      wr_ptr_s     = wr_ptr_r;
      pend_s       = pend_r;
      best_s       = best_r;
      tb_state_s   = tb_state_r;
      tb_ptr_s     = tb_ptr_r;
      steps_s      = steps_r;
      flushing_s   = flushing_r;
      out_bit_s    = out_bit_r;
      out_last_s   = out_last_r;
      flush_done_s = 1'b0;
      case (state_r)
         IDLE: begin
            if (flush) begin
               if (pend_r == '0) begin
                  flush_done_s = 1'b1;
               end else begin
                  flushing_s = 1'b1;
                  tb_state_s = best_r;
                  tb_ptr_s   = newest_s;
                  steps_s    = PW'(pend_r - PD'(1));
                  if (pend_r == PD'(1)) begin
                     state_s    = EMIT;
                     out_bit_s  = best_r[0];
                     out_last_s = 1'b1;
                  end else begin
                     state_s = TB;
                  end
               end
            end else if (acs_valid) begin
               mem_we_s = 1'b1;
               wr_ptr_s = wr_ptr_r + PW'(1);
               pend_s   = pend_r + PD'(1);
               best_s   = acs_best;
               if (pend_r == PD'(D_TB - 1)) begin
                  state_s    = TB;
                  tb_state_s = acs_best;
                  tb_ptr_s   = wr_ptr_r;
                  steps_s    = PW'(D_TB - 1);
               end else begin
                  state_s = IDLE;
               end
            end else begin
               state_s = IDLE;
            end
         end
         TB: begin
            tb_state_s = tb_step_s;
            tb_ptr_s   = tb_ptr_r - PW'(1);
            steps_s    = steps_r - PW'(1);
            if (steps_r == PW'(1)) begin
               state_s    = EMIT;
               out_bit_s  = tb_step_s[0];
               out_last_s = flushing_r & (pend_r == PD'(1));
            end else begin
               state_s = TB;
            end
         end
         EMIT: begin
            if (out_ready) begin
               pend_s = pend_r - PD'(1);
               if (!flushing_r) begin
                  state_s = IDLE;
               end else if (pend_r == PD'(1)) begin
                  flush_done_s = 1'b1;
                  flushing_s   = 1'b0;
                  wr_ptr_s     = '0;
                  state_s      = IDLE;
               end else begin
                  // Next flush bit restarts from the newest symbol, one step shorter.
                  tb_state_s = best_r;
                  tb_ptr_s   = newest_s;
                  steps_s    = PW'(pend_r - PD'(2));
                  if (pend_r == PD'(2)) begin
                     state_s    = EMIT;
                     out_bit_s  = best_r[0];
                     out_last_s = 1'b1;
                  end else begin
                     state_s = TB;
                  end
               end
            end else begin
               state_s = EMIT;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // Control and output registers; reset discards any pending bit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r      <= IDLE;
         wr_ptr_r     <= '0;
         pend_r       <= '0;
         best_r       <= '0;
         tb_state_r   <= '0;
         tb_ptr_r     <= '0;
         steps_r      <= '0;
         flushing_r   <= 1'b0;
         out_bit_r    <= 1'b0;
         out_last_r   <= 1'b0;
         out_valid_r  <= 1'b0;
         flush_done_r <= 1'b0;
         busy_r       <= 1'b0;
      end else begin
         state_r      <= state_s;
         wr_ptr_r     <= wr_ptr_s;
         pend_r       <= pend_s;
         best_r       <= best_s;
         tb_state_r   <= tb_state_s;
         tb_ptr_r     <= tb_ptr_s;
         steps_r      <= steps_s;
         flushing_r   <= flushing_s;
         out_bit_r    <= out_bit_s;
         out_last_r   <= out_last_s;
         out_valid_r  <= (state_s == EMIT);
         flush_done_r <= flush_done_s;
         busy_r       <= (state_s != IDLE);
      end
   end

endmodule

// File: tb/tb_viterbi_tb_ctrl.sv
// Scoreboard bench for viterbi_tb_ctrl: a reference traceback model queues expected
// bits at each transfer/flush and a negedge monitor compares them on every handshake.
module tb_viterbi_tb_ctrl;

   localparam int D = 32;

   logic        clk = 1'b0;
   logic        rst;
   logic        acs_valid;
   logic        acs_ready;
   logic [15:0] acs_dec;
   logic [3:0]  acs_best;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic        out_bit;
   logic        out_last;
   logic        flush_done;
   logic        busy;

   viterbi_tb_ctrl #(.K(5), .D_TB(D)) dut (
      .clk        (clk),
      .rst        (rst),
      .acs_valid  (acs_valid),
      .acs_ready  (acs_ready),
      .acs_dec    (acs_dec),
      .acs_best   (acs_best),
      .flush      (flush),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_bit    (out_bit),
      .out_last   (out_last),
      .flush_done (flush_done),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic b;
      logic l;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        exp_e;
   logic [15:0] mem_m [D];
   int          wr_m, pend_m;
   logic [3:0]  best_m;
   int          n_checks = 0;
   int          n_pass = 0;
   int          exp_fd = 0;
   int          fd_cnt = 0;
   int          ones_cnt = 0;
   int          last_cnt = 0;
   int          bits_cnt = 0;
   longint      t_prev, t_now;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic logic ref_bit(input logic [3:0] s0, input int idx, input int steps);
      logic [3:0]  s;
      logic [15:0] v;
      int          p;
      s = s0;
      p = idx;
      for (int i = 0; i < steps; i++) begin
         v = mem_m[p];
         s = {v[s], s[3:1]};
         p = (p + D - 1) % D;
      end
      return s[0];
   endfunction

   // Handshake monitor: pops the scoreboard on every accepted bit.
   always @(negedge clk) begin
      if (flush_done) fd_cnt <= fd_cnt + 1;
      if (!rst && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_out", 32'd1, 32'd0);
         end else begin
            exp_e = exp_q.pop_front();
            check("out_bit", {31'd0, out_bit}, {31'd0, exp_e.b});
            check("out_last", {31'd0, out_last}, {31'd0, exp_e.l});
         end
         bits_cnt <= bits_cnt + 1;
         ones_cnt <= ones_cnt + int'(out_bit);
         last_cnt <= last_cnt + int'(out_last);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      exp_q.delete();
      wr_m   = 0;
      pend_m = 0;
      best_m = 4'h0;
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      acs_valid = 1'b0;
      flush     = 1'b0;
      out_ready = 1'b1;
      step();
      step();
      rst = 1'b0;
      model_reset();
      check("rst_acs_ready", {31'd0, acs_ready}, 32'd1);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_out_bit", {31'd0, out_bit}, 32'd0);
      check("rst_out_last", {31'd0, out_last}, 32'd0);
      check("rst_flush_done", {31'd0, flush_done}, 32'd0);
   endtask

   task automatic xfer(input logic [15:0] dec, input logic [3:0] best);
      int n = 0;
      while (!acs_ready && n < 200) begin
         step();
         n++;
      end
      check("xfer_ready", {31'd0, acs_ready}, 32'd1);
      acs_valid = 1'b1;
      acs_dec   = dec;
      acs_best  = best;
      @(posedge clk);
      t_prev = t_now;
      t_now  = $time;
      mem_m[wr_m] = dec;
      best_m      = best;
      pend_m++;
      if (pend_m == D) begin
         exp_q.push_back('{ref_bit(best, wr_m, D - 1), 1'b0});
         pend_m--;
      end
      wr_m = (wr_m + 1) % D;
      #1;
      acs_valid = 1'b0;
   endtask

   task automatic do_flush(input logic with_valid);
      int n = 0;
      while (busy && n < 4000) begin
         step();
         n++;
      end
      check("flush_from_idle", {31'd0, busy}, 32'd0);
      flush     = 1'b1;
      acs_valid = with_valid;
      acs_dec   = 16'hFFFF;
      acs_best  = 4'hA;
      #1;
      check("ready_low_flush", {31'd0, acs_ready}, 32'd0);
      @(posedge clk);
      if (pend_m > 0) begin
         for (int p = pend_m; p >= 1; p--) begin
            exp_q.push_back('{ref_bit(best_m, (wr_m + D - 1) % D, p - 1), (p == 1)});
         end
         pend_m = 0;
         wr_m   = 0;
      end
      exp_fd++;
      #1;
      flush     = 1'b0;
      acs_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while ((busy || exp_q.size() != 0) && n < 4000) begin
         step();
         n++;
      end
      check("drain_done", {31'd0, (busy || exp_q.size() != 0)}, 32'd0);
      step();
   endtask

   initial begin
      int n, b0, o0, l0, f0;
      rst = 1'b1; acs_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
      acs_dec = 16'h0000; acs_best = 4'h0; t_prev = 0; t_now = 0;
      model_reset();
      do_reset();

      // Fill: 31 silent transfers, then the 32nd yields a bit 32 cycles later.
      for (int i = 0; i < D - 1; i++) begin
         xfer(16'h0000, 4'h0);
         check("fill_no_out", {31'd0, out_valid}, 32'd0);
         check("fill_ready", {31'd0, acs_ready}, 32'd1);
      end
      xfer(16'h0000, 4'h0);
      check("tb_busy", {31'd0, busy}, 32'd1);
      n = 1;
      while (!out_valid && n < 100) begin
         step();
         n++;
      end
      check("first_latency", n, 32'd32);
      drain();

      // All-ones decisions: transfers 33 cycles apart, ones once the window holds 28+.
      o0 = ones_cnt;
      for (int i = 0; i < D + 1; i++) begin
         xfer(16'hFFFF, 4'hF);
         if (i > 0) check("xfer_spacing", 32'((t_now - t_prev) / 10), 32'd33);
      end
      drain();
      check("ones_count", ones_cnt - o0, 32'd6);

      // Flush after a zero fill ending in best state F.
      do_reset();
      for (int i = 0; i < D - 1; i++) xfer(16'h0000, 4'h0);
      xfer(16'h0000, 4'hF);
      drain();
      b0 = bits_cnt; o0 = ones_cnt; l0 = last_cnt; f0 = fd_cnt;
      do_flush(1'b0);
      drain();
      check("flush_bits", bits_cnt - b0, 32'd31);
      check("flush_ones", ones_cnt - o0, 32'd4);
      check("flush_last", last_cnt - l0, 32'd1);
      check("flush_done_once", fd_cnt - f0, 32'd1);

      // Backpressure during EMIT.
      do_reset();
      for (int i = 0; i < D - 1; i++) xfer(16'($urandom), 4'($urandom));
      out_ready = 1'b0;
      xfer(16'($urandom), 4'($urandom));
      n = 0;
      while (!out_valid && n < 100) begin
         step();
         n++;
      end
      for (int i = 0; i < 10; i++) begin
         step();
         check("stall_valid", {31'd0, out_valid}, 32'd1);
         check("stall_bit", {31'd0, out_bit}, {31'd0, exp_q[0].b});
         check("stall_last", {31'd0, out_last}, 32'd0);
         check("stall_ready", {31'd0, acs_ready}, 32'd0);
         check("stall_busy", {31'd0, busy}, 32'd1);
      end
      out_ready = 1'b1;
      step();
      check("stall_accept", {31'd0, out_valid}, 32'd0);
      check("stall_popped", exp_q.size(), 32'd0);

      // Flush colliding with acs_valid at P=3, then an empty flush.
      do_reset();
      for (int i = 0; i < 3; i++) xfer(16'($urandom), 4'($urandom));
      b0 = bits_cnt; f0 = fd_cnt;
      do_flush(1'b1);
      drain();
      check("p3_bits", bits_cnt - b0, 32'd3);
      check("p3_flush_done", fd_cnt - f0, 32'd1);
      do_flush(1'b0);
      check("empty_fd_pulse", {31'd0, flush_done}, 32'd1);
      check("empty_no_valid", {31'd0, out_valid}, 32'd0);
      step();
      check("empty_fd_low", {31'd0, flush_done}, 32'd0);

      // Reset in the middle of a traceback.
      do_reset();
      for (int i = 0; i < D; i++) xfer(16'($urandom), 4'($urandom));
      for (int i = 0; i < 14; i++) step();
      check("mid_tb_busy", {31'd0, busy}, 32'd1);
      rst = 1'b1;
      #1;
      check("rst_mid_busy", {31'd0, busy}, 32'd0);
      check("rst_mid_valid", {31'd0, out_valid}, 32'd0);
      model_reset();
      step();
      step();
      rst = 1'b0;
      for (int i = 0; i < D - 1; i++) begin
         xfer(16'($urandom), 4'($urandom));
         check("post_rst_silent", {31'd0, out_valid}, 32'd0);
      end
      step();
      check("fd_total", fd_cnt, exp_fd);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
